// File: rtl/otter_mem_pkg.sv
// otter_mem_pkg: shared types and widths for the OTTER memory arbiter.
//   state_t  - arbiter FSM states
//   owner_t  - which requester owns the current transaction
//   cmd_t    - latched memory command (write enable, byte enables, address, write data)
package otter_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/otter_arb_timer.sv
// otter_arb_timer: counts cycles while enabled and flags the last allowed one.
//   clk, rst_n - clock, async active-low reset
//   clear      - zero the count (held while the arbiter is outside ACCESS)
//   enable     - count this cycle (arbiter is in ACCESS)
//   expired    - high during the TIMEOUT-th enabled cycle
module otter_arb_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (clear)
            tmo_cnt <= '0;
        else if (enable && tmo_cnt != CW'(TIMEOUT))
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Count starts at 0 in the first ACCESS cycle, so TIMEOUT-1 marks the last one.
    assign expired = enable && (tmo_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: shares one memory port between instruction fetch and data.
//   clk, rst_n                      - clock, async active-low reset
//   i_req/i_addr                    - fetch read request
//   i_gnt/i_rvalid/i_rdata/i_err    - fetch grant, completion, data, error
//   d_req/d_we/d_be/d_addr/d_wdata  - data request and command
//   d_gnt/d_rvalid/d_rdata/d_err    - data grant, completion, data, error
//   mem_*                           - shared memory port, mem_ack completes
//   busy                            - FSM not idle
module otter_mem_arbiter
    import otter_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [BE_W-1:0]   d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_t            state, state_d;
    owner_t            owner;
    cmd_t              cmd;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [SW-1:0]     starve_cnt;
    logic              pick_i, pick_d;
    logic              in_access, in_resp, expired;

    assign in_access = (state == ST_ACCESS);
    assign in_resp   = (state == ST_RESP);

    // Data wins ties unless fetch has already lost STARVE_LIMIT times in a row.
    assign pick_d = d_req && (!i_req || starve_cnt != SW'(STARVE_LIMIT));
    assign pick_i = i_req && !pick_d;

    // Grants are combinational from req; masked by rst_n so reset zeroes them.
    assign i_gnt = rst_n && (state == ST_IDLE) && pick_i;
    assign d_gnt = rst_n && (state == ST_IDLE) && pick_d;

    otter_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_access),
        .enable  (in_access),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE:   if (i_req || d_req)     state_d = ST_ACCESS;
            ST_ACCESS: if (mem_ack || expired) state_d = ST_RESP;
            ST_RESP:                           state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= OWN_I;
            cmd        <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (state == ST_IDLE && (pick_i || pick_d)) begin
                if (pick_d) begin
                    owner      <= OWN_D;
                    cmd.we     <= d_we;
                    cmd.be     <= d_be;
                    cmd.addr   <= d_addr;
                    cmd.wdata  <= d_wdata;
                    if (i_req && starve_cnt != SW'(STARVE_LIMIT))
                        starve_cnt <= starve_cnt + 1'b1;
                end else begin
                    owner      <= OWN_I;
                    cmd.we     <= 1'b0;
                    cmd.be     <= '1;
                    cmd.addr   <= i_addr;
                    cmd.wdata  <= '0;
                    starve_cnt <= '0;
                end
            end
            if (in_access) begin
                // mem_ack takes precedence over a timeout in the same cycle.
                if (mem_ack) begin
                    rdata_q <= cmd.we ? '0 : mem_rdata;
                    err_q   <= 1'b0;
                end else if (expired) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign mem_req   = in_access;
    assign mem_we    = in_access && cmd.we;
    assign mem_be    = in_access ? cmd.be    : '0;
    assign mem_addr  = in_access ? cmd.addr  : '0;
    assign mem_wdata = in_access ? cmd.wdata : '0;

    assign i_rvalid  = in_resp && (owner == OWN_I);
    assign d_rvalid  = in_resp && (owner == OWN_D);
    assign i_rdata   = i_rvalid ? rdata_q : '0;
    assign d_rdata   = d_rvalid ? rdata_q : '0;
    assign i_err     = i_rvalid && err_q;
    assign d_err     = d_rvalid && err_q;

    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_otter_mem_arbiter.sv
module tb_otter_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;

    int ncmp = 0;
    int nfail = 0;

    otter_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".busy"},     busy,     0);
        chk({tag, ".mem_req"},  mem_req,  0);
        chk({tag, ".mem_addr"}, mem_addr, 0);
        chk({tag, ".i_rvalid"}, i_rvalid, 0);
        chk({tag, ".d_rvalid"}, d_rvalid, 0);
        chk({tag, ".i_err"},    i_err,    0);
        chk({tag, ".d_err"},    d_err,    0);
    endtask

    initial begin
        rst_n = 0; i_req = 1; i_addr = 32'h100;
        d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
        #1;
        // reset: everything low, even with a pending fetch
        chk_quiet("rst");
        chk("rst.i_gnt", i_gnt, 0);
        chk("rst.d_gnt", d_gnt, 0);

        cyc(); rst_n = 1; i_req = 0;

        // fetch only, ack on third ACCESS cycle
        cyc(); i_req = 1; i_addr = 32'h100; #1;
        chk("f.i_gnt", i_gnt, 1);
        chk("f.d_gnt", d_gnt, 0);
        cyc(); i_req = 0; #1;
        chk("f.mem_req", mem_req, 1);
        chk("f.mem_addr", mem_addr, 32'h100);
        chk("f.mem_we", mem_we, 0);
        chk("f.mem_be", mem_be, 4'hF);
        chk("f.busy", busy, 1);
        cyc();
        cyc(); mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        cyc(); mem_ack = 0; #1;
        chk("f.i_rvalid", i_rvalid, 1);
        chk("f.i_rdata", i_rdata, 32'hDEADBEEF);
        chk("f.i_err", i_err, 0);
        chk("f.d_rvalid", d_rvalid, 0);
        chk("f.mem_req_off", mem_req, 0);
        cyc(); #1;
        chk("f.rvalid_pulse", i_rvalid, 0);
        chk("f.idle", busy, 0);

        // simultaneous requests: data write first, then fetch
        i_req = 1; i_addr = 32'h200;
        d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h300; d_wdata = 32'h1234; #1;
        chk("s.d_gnt", d_gnt, 1);
        chk("s.i_gnt", i_gnt, 0);
        cyc(); d_req = 0; #1;
        chk("s.mem_we", mem_we, 1);
        chk("s.mem_be", mem_be, 4'h3);
        chk("s.mem_addr", mem_addr, 32'h300);
        chk("s.mem_wdata", mem_wdata, 32'h1234);
        chk("s.i_gnt_access", i_gnt, 0);
        mem_ack = 1; mem_rdata = 32'hFFFF0000;
        cyc(); mem_ack = 0; #1;
        chk("s.d_rvalid", d_rvalid, 1);
        chk("s.d_rdata_wr", d_rdata, 0);
        chk("s.i_gnt_resp", i_gnt, 0);
        cyc(); #1;
        chk("s.i_gnt", i_gnt, 1);
        cyc(); i_req = 0; mem_ack = 1; mem_rdata = 32'h55; #1;
        chk("s.f_mem_addr", mem_addr, 32'h200);
        chk("s.f_mem_we", mem_we, 0);
        chk("s.f_mem_be", mem_be, 4'hF);
        cyc(); mem_ack = 0; #1;
        chk("s.i_rvalid", i_rvalid, 1);
        chk("s.i_rdata", i_rdata, 32'h55);
        cyc();

        // starvation: four data wins, then fetch, then data again (counter cleared)
        for (int k = 0; k < 6; k++) begin
            i_req = 1; i_addr = 32'h900;
            d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h800 + k;
            mem_ack = 1; mem_rdata = 32'hA0 + k; #1;
            chk($sformatf("st%0d.i_gnt", k), i_gnt, (k == 4) ? 1 : 0);
            chk($sformatf("st%0d.d_gnt", k), d_gnt, (k == 4) ? 0 : 1);
            cyc(); #1;
            chk($sformatf("st%0d.mem_addr", k), mem_addr, (k == 4) ? 32'h900 : 32'h800 + k);
            cyc(); #1;
            chk($sformatf("st%0d.i_rvalid", k), i_rvalid, (k == 4) ? 1 : 0);
            chk($sformatf("st%0d.d_rvalid", k), d_rvalid, (k == 4) ? 0 : 1);
            chk($sformatf("st%0d.rdata", k), (k == 4) ? i_rdata : d_rdata, 32'hA0 + k);
            cyc();
        end
        i_req = 0; d_req = 0; mem_ack = 0; mem_rdata = 32'h12345678;

        // timeout: no ack for 15 ACCESS cycles
        d_req = 1; d_we = 0; d_addr = 32'h400; #1;
        chk("t.d_gnt", d_gnt, 1);
        for (int c = 1; c <= 15; c++) begin
            cyc(); d_req = 0; #1;
            chk($sformatf("t.mem_req%0d", c), mem_req, 1);
        end
        cyc(); #1;
        chk("t.mem_req_drop", mem_req, 0);
        chk("t.d_rvalid", d_rvalid, 1);
        chk("t.d_err", d_err, 1);
        chk("t.d_rdata", d_rdata, 0);
        chk("t.i_rvalid", i_rvalid, 0);
        cyc(); #1;
        chk("t.idle", busy, 0);
        chk("t.rvalid_pulse", d_rvalid, 0);

        // ack on exactly the 15th ACCESS cycle beats the timeout
        i_req = 1; i_addr = 32'h500; #1;
        chk("a.i_gnt", i_gnt, 1);
        for (int c = 1; c <= 15; c++) begin
            cyc(); i_req = 0;
            if (c == 15) begin mem_ack = 1; mem_rdata = 32'hCAFEF00D; end
            #1;
            chk($sformatf("a.mem_req%0d", c), mem_req, 1);
        end
        cyc(); mem_ack = 0; #1;
        chk("a.i_rvalid", i_rvalid, 1);
        chk("a.i_err", i_err, 0);
        chk("a.i_rdata", i_rdata, 32'hCAFEF00D);
        cyc(); #1;
        chk("a.idle", busy, 0);

        // reset pulse during ACCESS, stray ack afterwards
        d_req = 1; d_we = 0; d_addr = 32'h600; #1;
        chk("r.d_gnt", d_gnt, 1);
        cyc(); d_req = 0; #1;
        chk("r.mem_req", mem_req, 1);
        #1 rst_n = 0; #1;
        chk_quiet("r.in_rst");
        chk("r.d_gnt_rst", d_gnt, 0);
        mem_ack = 1; mem_rdata = 32'hBAD;
        cyc(); rst_n = 1; #1;
        chk_quiet("r.release");
        cyc(); #1;
        chk_quiet("r.stray_ack");
        mem_ack = 0;
        i_req = 1; i_addr = 32'h700; #1;
        chk("r.i_gnt", i_gnt, 1);
        cyc(); i_req = 0; mem_ack = 1; mem_rdata = 32'h77; #1;
        chk("r.mem_addr", mem_addr, 32'h700);
        chk("r.mem_req_new", mem_req, 1);
        cyc(); mem_ack = 0; #1;
        chk("r.i_rvalid", i_rvalid, 1);
        chk("r.i_rdata", i_rdata, 32'h77);
        chk("r.d_rvalid", d_rvalid, 0);
        cyc(); #1;
        chk("r.idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
